freq_calc: RTL and testbench
============================

Name: freq_calc

Overview:
- Downstream stage of the equal-precision frequency meter counter core.
- Consumes the finished gate-window counts: Nx, the unknown-signal count, and Ns, the standard-clock count.
- Computes fx = round(Nx * FSTD / Ns) with a sequential shift-add multiplier followed by a restoring divider.
- Presents a 32-bit Hz result with done/err/ovf flags, for the byte-wide readout mux or the MCU.

Parameters:
- FSTD, 50000000, standard clock frequency in Hz; must be < 2^32.
- W, 32, width of count inputs and of the result.

Ports:
- clkin  in  1  system clock; same domain as the standard-count counter.
- clr0  in  1  reset, asynchronous, active-high.
- load  in  1  counts-final level from the standard counter; a rising edge starts a calculation.
- nx  in  W  unknown-signal count.
- ns  in  W  standard-clock count.
- freq  out  W  result in Hz; holds its value until the next completion.
- done  out  1  one-cycle pulse when freq/err/ovf are updated.
- busy  out  1  high from capture until done.
- err  out  1  ns was 0 on the last calculation; sticky until the next capture.
- ovf  out  1  result saturated to all-ones; sticky until the next capture.

Behaviour:
- Reset (clr0=1, async): freq=0, done=0, busy=0, err=0, ovf=0, state=IDLE, load_d=0. All datapath registers clear.
- clr0 mid-calculation aborts immediately. No done is issued.
- load is synchronous to clkin. No synchroniser is used.
- Start is detected on (load & ~load_d); load_d is registered every cycle.
- Start edges while busy=1 are ignored. A constant-high load never retriggers.
- FSM states: IDLE, MUL, DIV, RND, FIN.
- IDLE, on start edge E1 (call it capture):
  - Latch nx and ns. Clear err and ovf. busy<=1.
  - If ns==0: next state FIN with error path.
  - Else: mcand<=FSTD (2W bits), mplier<=nx, acc<=0, cnt<=0, next state MUL.
- MUL, W cycles:
  - If mplier[0]=1, acc+=mcand.
  - Then mcand<<=1, mplier>>=1.
  - After cnt==W-1, go to DIV. At that point acc = nx*FSTD exactly (2W bits).
- DIV, 2W cycles, restoring division:
  - rem (W+1 bits) = {rem, dividend MSB}.
  - If rem >= ns: rem -= ns and the quotient bit is 1.
  - The dividend shifts left and the quotient (2W bits) shifts in.
- RND, 1 cycle:
  - If 2*rem >= ns (compare at W+1 bits), q+=1. This is round half up.
  - If q > 2^W-1: result=all-ones, ovf=1. Otherwise result=q[W-1:0].
- FIN, 1 cycle:
  - freq<=result, done<=1, busy<=0, next state IDLE.
  - Error path: freq<=all-ones, err=1, ovf=0.
- Latency, normal path: capture at edge E1; MUL at E2..E33; DIV at E34..E97; RND at E98. freq/done update at E99; done is high for the cycle after E99.
- Latency, ns==0 path: freq/done update at edge E2.
- Inputs nx/ns may change after capture without effect.
- A start edge in the cycle right after FIN (state IDLE) is accepted.

Decomposition:
- Package freq_meter_pkg holds:
  - the FSM state enum {IDLE, MUL, DIV, RND, FIN};
  - the constants W=32 and FSTD_DEFAULT=50000000;
  - the latency constant CALC_CYCLES=98.
- One sub-module: seq_div64by32 holds the DIV state's iterations.
  - Ports: start, dividend[63:0], divisor[31:0], quot[63:0], rem[31:0], done.
  - freq_calc keeps the FSM, the multiplier and the rounding.

Test Plan:
- nx=1000, ns=50000000, load rises → freq=1000 at capture+98 edges; done for 1 cycle; err=0, ovf=0; busy high for exactly 98 cycles.
- nx=3, ns=7 → 150000000/7=21428571.43 → freq=21428571.
- nx=1, ns=3 → 16666666.67 → rounds up to freq=16666667.
- nx=1, ns=2 under FSTD=3 (exact half, 1.5) → freq=2. Then nx=0, ns=5 → freq=0.
- nx=32'hFFFFFFFF, ns=1 → freq=32'hFFFFFFFF, ovf=1. Then ns=0 → freq=FFFFFFFF, err=1, done at capture+1.
- Abort and retrigger: pulse clr0 at capture+40 → no done, all outputs 0. Then a load edge while busy is ignored, and a held-high load gives only one calculation.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the equal-precision frequency meter datapath.
package freq_meter_pkg;

   localparam int          W            = 32;
   localparam logic [31:0] FSTD_DEFAULT = 32'd50000000;
   localparam int          CALC_CYCLES  = 98;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      RND  = 3'd3,
      FIN  = 3'd4
   } state_e;

   // Round half up: bump the quotient when twice the remainder reaches the divisor.
   function automatic logic round_half_up(input logic [31:0] rem, input logic [31:0] divisor);
      return ({rem, 1'b0} >= {1'b0, divisor});
   endfunction

endpackage

// File: rtl/seq_div64by32.sv
// Restoring divider, one quotient bit per clock, 64 iterations after start.
module seq_div64by32 (
   input  logic        clkin,
   input  logic        clr0,
   input  logic        start,
   input  logic [63:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] quot,
   output logic [31:0] rem,
   output logic        done
);

   logic [63:0] dvd_q, dvd_d;
   logic [63:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic        done_q, done_d;
   logic [32:0] trial_s;

   // Next-state for one restoring step; divisor must stay stable while running.
   always_comb begin
      dvd_d   = dvd_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      done_d  = 1'b0;
      trial_s = {rem_q, dvd_q[63]};
      if (start) begin
         dvd_d  = dividend;
         quot_d = 64'd0;
         rem_d  = 32'd0;
         cnt_d  = 6'd0;
         run_d  = 1'b1;
      end else if (run_q) begin
         dvd_d = {dvd_q[62:0], 1'b0};
         if (trial_s >= {1'b0, divisor}) begin
            rem_d  = trial_s[31:0] - divisor;
            quot_d = {quot_q[62:0], 1'b1};
         end else begin
            rem_d  = trial_s[31:0];
            quot_d = {quot_q[62:0], 1'b0};
         end
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == 6'd63) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            run_d  = 1'b1;
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clkin or posedge clr0) begin
      if (clr0) begin
         dvd_q  <= 64'd0;
         quot_q <= 64'd0;
         rem_q  <= 32'd0;
         cnt_q  <= 6'd0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign quot = quot_q;
   assign rem  = rem_q;
   assign done = done_q;

endmodule

// File: rtl/freq_calc.sv
// fx = round(Nx * FSTD / Ns): shift-add multiply, restoring divide, round half up,
// saturate to all-ones; ns==0 reports err with an all-ones result.
module freq_calc #(
   parameter logic [31:0] FSTD = freq_meter_pkg::FSTD_DEFAULT,
   parameter int          W    = freq_meter_pkg::W
) (
   input  logic         clkin,
   input  logic         clr0,
   input  logic         load,
   input  logic [W-1:0] nx,
   input  logic [W-1:0] ns,
   output logic [W-1:0] freq,
   output logic         done,
   output logic         busy,
   output logic         err,
   output logic         ovf
);
   import freq_meter_pkg::*;

   state_e         state_q, state_d;
   logic           load_dly_q, load_dly_d;
   logic [W-1:0]   ns_q, ns_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [W-1:0]   result_q, result_d;
   logic           sat_q, sat_d;
   logic           zero_q, zero_d;
   logic [W-1:0]   freq_q, freq_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           err_q, err_d;
   logic           ovf_q, ovf_d;

   logic           start_s;
   logic           div_start_s;
   logic [2*W-1:0] div_quot_s;
   logic [W-1:0]   div_rem_s;
   logic           div_done_s;
   logic [2*W:0]   q_rnd_s;

   // The divider loads the final product on the last multiply step.
   seq_div64by32 u_div (
      .clkin    (clkin),
      .clr0     (clr0),
      .start    (div_start_s),
      .dividend (acc_d),
      .divisor  (ns_q),
      .quot     (div_quot_s),
      .rem      (div_rem_s),
      .done     (div_done_s)
   );

   // FSM next-state, multiplier step, rounding and output updates.
   always_comb begin
      state_d     = state_q;
      load_dly_d  = load;
      ns_d        = ns_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      sat_d       = sat_q;
      zero_d      = zero_q;
      freq_d      = freq_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      div_start_s = 1'b0;
      start_s     = load & ~load_dly_q;
      q_rnd_s     = {1'b0, div_quot_s} + {{(2*W){1'b0}}, round_half_up(div_rem_s, ns_q)};
      case (state_q)
         IDLE: begin
            if (start_s) begin
               ns_d     = ns;
               err_d    = 1'b0;
               ovf_d    = 1'b0;
               sat_d    = 1'b0;
               busy_d   = 1'b1;
               mcand_d  = {{W{1'b0}}, FSTD};
               mplier_d = nx;
               acc_d    = {(2*W){1'b0}};
               cnt_d    = 6'd0;
               if (ns == {W{1'b0}}) begin
                  zero_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  zero_d  = 1'b0;
                  state_d = MUL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end else begin
               acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == 6'(W-1)) begin
               cnt_d       = 6'd0;
               div_start_s = 1'b1;
               state_d     = DIV;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         DIV: begin
            if (cnt_q == 6'd63) begin
               cnt_d   = 6'd0;
               state_d = RND;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         RND: begin
            if (div_done_s) begin
               if (|q_rnd_s[2*W:W]) begin
                  result_d = {W{1'b1}};
                  sat_d    = 1'b1;
               end else begin
                  result_d = q_rnd_s[W-1:0];
                  sat_d    = 1'b0;
               end
               state_d = FIN;
            end else begin
               state_d = RND;
            end
         end
         FIN: begin
            freq_d  = zero_q ? {W{1'b1}} : result_q;
            err_d   = zero_q;
            ovf_d   = zero_q ? 1'b0 : sat_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; clr0 aborts any calculation in flight.
   always_ff @(posedge clkin or posedge clr0) begin
      if (clr0) begin
         state_q    <= IDLE;
         load_dly_q <= 1'b0;
         ns_q       <= {W{1'b0}};
         mcand_q    <= {(2*W){1'b0}};
         mplier_q   <= {W{1'b0}};
         acc_q      <= {(2*W){1'b0}};
         cnt_q      <= 6'd0;
         result_q   <= {W{1'b0}};
         sat_q      <= 1'b0;
         zero_q     <= 1'b0;
         freq_q     <= {W{1'b0}};
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_dly_q <= load_dly_d;
         ns_q       <= ns_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         sat_q      <= sat_d;
         zero_q     <= zero_d;
         freq_q     <= freq_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   assign freq = freq_q;
   assign done = done_q;
   assign busy = busy_q;
   assign err  = err_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: default FSTD instance plus an FSTD=3 instance for the exact-half case.
module tb_freq_calc;

   logic        clkin = 1'b0;
   logic        clr0;
   logic        load_a, load_b;
   logic [31:0] nx_a, ns_a, nx_b, ns_b;
   logic [31:0] freq_a, freq_b;
   logic        done_a, busy_a, err_a, ovf_a;
   logic        done_b, busy_b, err_b, ovf_b;

   int errors = 0;
   int checks = 0;
   int lat, bc, bad;

   always #5 clkin = ~clkin;

   freq_calc dut_a (
      .clkin(clkin), .clr0(clr0), .load(load_a), .nx(nx_a), .ns(ns_a),
      .freq(freq_a), .done(done_a), .busy(busy_a), .err(err_a), .ovf(ovf_a)
   );

   freq_calc #(.FSTD(32'd3)) dut_b (
      .clkin(clkin), .clr0(clr0), .load(load_b), .nx(nx_b), .ns(ns_b),
      .freq(freq_b), .done(done_b), .busy(busy_b), .err(err_b), .ovf(ovf_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] o_freq(input int sel);
      return (sel != 0) ? freq_b : freq_a;
   endfunction
   function automatic logic o_done(input int sel);
      return (sel != 0) ? done_b : done_a;
   endfunction
   function automatic logic o_busy(input int sel);
      return (sel != 0) ? busy_b : busy_a;
   endfunction
   function automatic logic o_err(input int sel);
      return (sel != 0) ? err_b : err_a;
   endfunction
   function automatic logic o_ovf(input int sel);
      return (sel != 0) ? ovf_b : ovf_a;
   endfunction

   // mode 0: load pulses for one cycle; mode 1: load held high with a drop/re-rise while busy.
   task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input int mode, output int lat_o, output int bc_o);
      @(negedge clkin);
      if (sel != 0) begin nx_b = a; ns_b = b; load_b = 1'b1; end
      else begin nx_a = a; ns_a = b; load_a = 1'b1; end
      @(posedge clkin); #1;
      chk("busy_at_capture", 64'(o_busy(sel)), 64'd1);
      chk("err_cleared_at_capture", 64'(o_err(sel)), 64'd0);
      chk("ovf_cleared_at_capture", 64'(o_ovf(sel)), 64'd0);
      bc_o  = o_busy(sel) ? 1 : 0;
      lat_o = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clkin);
         if (k == 1) begin
            if (sel != 0) begin nx_b = $urandom; ns_b = $urandom; end
            else begin nx_a = $urandom; ns_a = $urandom; end
            if (mode == 0) begin
               if (sel != 0) load_b = 1'b0; else load_a = 1'b0;
            end
         end
         if (mode == 1 && k == 10) begin
            if (sel != 0) load_b = 1'b0; else load_a = 1'b0;
         end
         if (mode == 1 && k == 11) begin
            if (sel != 0) load_b = 1'b1; else load_a = 1'b1;
         end
         @(posedge clkin); #1;
         if (o_done(sel)) begin
            lat_o = k;
            break;
         end
         if (o_busy(sel)) bc_o++;
      end
   endtask

   initial begin
      clr0 = 1'b1;
      load_a = 1'b0; load_b = 1'b0;
      nx_a = 32'd0; ns_a = 32'd0; nx_b = 32'd0; ns_b = 32'd0;
      #23;
      chk("reset_freq", 64'(freq_a), 64'd0);
      chk("reset_done", 64'(done_a), 64'd0);
      chk("reset_busy", 64'(busy_a), 64'd0);
      chk("reset_err", 64'(err_a), 64'd0);
      chk("reset_ovf", 64'(ovf_a), 64'd0);
      chk("reset_busy_b", 64'(busy_b), 64'd0);
      @(negedge clkin);
      clr0 = 1'b0;

      run(0, 32'd1000, 32'd50000000, 0, lat, bc);
      chk("lat_1000", 64'(lat), 64'd98);
      chk("busy_cycles_1000", 64'(bc), 64'd98);
      chk("freq_1000", 64'(freq_a), 64'd1000);
      chk("err_1000", 64'(err_a), 64'd0);
      chk("ovf_1000", 64'(ovf_a), 64'd0);
      chk("busy_low_at_done", 64'(busy_a), 64'd0);
      @(posedge clkin); #1;
      chk("done_one_cycle", 64'(done_a), 64'd0);
      chk("freq_holds", 64'(freq_a), 64'd1000);

      run(0, 32'd3, 32'd7, 0, lat, bc);
      chk("lat_3_7", 64'(lat), 64'd98);
      chk("freq_3_7", 64'(freq_a), 64'd21428571);

      run(0, 32'd1, 32'd3, 0, lat, bc);
      chk("freq_1_3_roundup", 64'(freq_a), 64'd16666667);

      run(1, 32'd1, 32'd2, 0, lat, bc);
      chk("lat_half", 64'(lat), 64'd98);
      chk("freq_half_up", 64'(freq_b), 64'd2);
      run(1, 32'd0, 32'd5, 0, lat, bc);
      chk("freq_zero_nx", 64'(freq_b), 64'd0);
      chk("ovf_zero_nx", 64'(ovf_b), 64'd0);

      run(0, 32'hFFFFFFFF, 32'd1, 0, lat, bc);
      chk("freq_sat", 64'(freq_a), 64'hFFFFFFFF);
      chk("ovf_sat", 64'(ovf_a), 64'd1);
      chk("err_sat", 64'(err_a), 64'd0);

      run(0, 32'd123, 32'd0, 0, lat, bc);
      chk("lat_ns0", 64'(lat), 64'd1);
      chk("busy_cycles_ns0", 64'(bc), 64'd1);
      chk("freq_ns0", 64'(freq_a), 64'hFFFFFFFF);
      chk("err_ns0", 64'(err_a), 64'd1);
      chk("ovf_ns0", 64'(ovf_a), 64'd0);

      // Start in the cycle right after FIN.
      run(0, 32'd1000, 32'd50000000, 0, lat, bc);
      chk("lat_back_to_back", 64'(lat), 64'd98);
      chk("freq_back_to_back", 64'(freq_a), 64'd1000);
      chk("err_back_to_back", 64'(err_a), 64'd0);

      // Abort mid-calculation.
      @(negedge clkin);
      nx_a = 32'd1000; ns_a = 32'd50000000; load_a = 1'b1;
      @(posedge clkin); #1;
      @(negedge clkin);
      load_a = 1'b0;
      repeat (39) @(posedge clkin);
      #1;
      clr0 = 1'b1;
      #1;
      chk("abort_freq", 64'(freq_a), 64'd0);
      chk("abort_busy", 64'(busy_a), 64'd0);
      chk("abort_done", 64'(done_a), 64'd0);
      chk("abort_err", 64'(err_a), 64'd0);
      chk("abort_ovf", 64'(ovf_a), 64'd0);
      @(negedge clkin);
      clr0 = 1'b0;
      bad = 0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clkin); #1;
         if (done_a || busy_a) bad++;
      end
      chk("abort_no_done", 64'(bad), 64'd0);

      // Held-high load with a re-rise while busy: one calculation only.
      run(0, 32'd7, 32'd50000000, 1, lat, bc);
      chk("lat_retrig_ignored", 64'(lat), 64'd98);
      chk("freq_retrig", 64'(freq_a), 64'd7);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clkin); #1;
         if (done_a || busy_a) bad++;
      end
      chk("held_load_no_retrigger", 64'(bad), 64'd0);
      @(negedge clkin);
      load_a = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
